// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer state codes and ALU op codes.
// The ALU and the datapath top import this package too, so codes change here only.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_F1    = 4'd1,
        ST_F2    = 4'd2,
        ST_DEC   = 4'd3,
        ST_EADDR = 4'd4,
        ST_EMEM  = 4'd5,
        ST_EALU  = 4'd6,
        ST_HALT  = 4'd7
    } state_t;

    // Opcodes that need an operand address phase followed by a memory access.
    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic [1:0] alu_code(input logic [OPCODE_W-1:0] op);
        logic [1:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            default: code = ALU_PASS;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Registered state with async reset; strobes are a combinational decode of state and status inputs.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int OPW = 4,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] ir_op,
    input  logic           acc_zero,
    input  logic           mem_ready,
    output logic           pc_load,
    output logic           pc_inc,
    output logic           mar_load,
    output logic           mar_sel,
    output logic           ir_load,
    output logic           mdr_load,
    output logic           acc_load,
    output logic [1:0]     alu_op,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           halted,
    output logic           illegal,
    output logic [STW-1:0] state_dbg
);

    state_t state_q;
    state_t state_d;
    logic [OPCODE_W-1:0] op;

    assign op        = OPCODE_W'(ir_op);
    assign state_dbg = STW'(state_q);

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode. Every strobe defaults low so each state only names what it drives.
    always_comb begin
        state_d  = state_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        mar_sel  = 1'b0;
        ir_load  = 1'b0;
        mdr_load = 1'b0;
        acc_load = 1'b0;
        alu_op   = ALU_PASS;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_F1;
                end
            end

            ST_F1: begin
                mar_load = 1'b1;
                state_d  = ST_F2;
            end

            ST_F2: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DEC;
                end
            end

            // Undefined opcodes behave as NOP apart from the one-cycle illegal flag.
            ST_DEC: begin
                state_d = ST_F1;
                case (op)
                    OP_NOP: ;
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = acc_zero;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_EADDR;
                    OP_HLT: state_d = ST_HALT;
                    default: illegal = 1'b1;
                endcase
            end

            ST_EADDR: begin
                mar_load = 1'b1;
                mar_sel  = 1'b1;
                state_d  = ST_EMEM;
            end

            ST_EMEM: begin
                if (op == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ready) begin
                    if (op == OP_STA) begin
                        state_d = ST_F1;
                    end else begin
                        mdr_load = 1'b1;
                        state_d  = ST_EALU;
                    end
                end
            end

            ST_EALU: begin
                acc_load = 1'b1;
                alu_op   = alu_code(op);
                state_d  = ST_F1;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            // Encodings outside the state set recover to IDLE with all strobes low.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed scenarios plus random instruction streams
// compared cycle by cycle against an instruction-level micro-step model.
module tb_cpu_control_fsm;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ir_op = 4'h0;
    logic        acc_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_load, pc_inc, mar_load, mar_sel, ir_load, mdr_load, acc_load;
    logic [1:0]  alu_op;
    logic        mem_rd, mem_wr, halted, illegal;
    logic [3:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // Bit positions of the observed strobe vector.
    localparam logic [12:0] S_PCL  = 13'h1000;
    localparam logic [12:0] S_PCI  = 13'h0800;
    localparam logic [12:0] S_MARL = 13'h0400;
    localparam logic [12:0] S_MARS = 13'h0200;
    localparam logic [12:0] S_IRL  = 13'h0100;
    localparam logic [12:0] S_MDRL = 13'h0080;
    localparam logic [12:0] S_ACCL = 13'h0040;
    localparam logic [12:0] S_RD   = 13'h0008;
    localparam logic [12:0] S_WR   = 13'h0004;
    localparam logic [12:0] S_HALT = 13'h0002;
    localparam logic [12:0] S_ILL  = 13'h0001;

    typedef struct {
        state_t      st;
        logic [12:0] sig;
        logic        ready;
        logic [3:0]  op;
        logic        az;
        logic        go;
    } step_t;

    step_t q[$];

    cpu_control_fsm #(.OPW(4), .STW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ir_op(ir_op), .acc_zero(acc_zero),
        .mem_ready(mem_ready), .pc_load(pc_load), .pc_inc(pc_inc), .mar_load(mar_load),
        .mar_sel(mar_sel), .ir_load(ir_load), .mdr_load(mdr_load), .acc_load(acc_load),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic legal_op(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
    endfunction

    task automatic pushStep(input state_t st, input logic [12:0] sig, input logic ready,
                            input logic [3:0] op, input logic az, input logic go);
        step_t s;
        s.st = st; s.sig = sig; s.ready = ready; s.op = op; s.az = az; s.go = go;
        q.push_back(s);
    endtask

    task automatic pushIdle(input logic go);
        pushStep(ST_IDLE, 13'h0, rbit(), rop(), rbit(), go);
    endtask

    task automatic pushF1();
        pushStep(ST_F1, S_MARL, rbit(), rop(), rbit(), rbit());
    endtask

    // One instruction as micro-steps: fetch address, instruction read with waits, decode, operand work.
    task automatic pushInstr(input logic [3:0] op, input logic az, input int wf2, input int wmem);
        logic [12:0] dsig;
        logic [12:0] acc;
        logic [1:0]  alu;
        pushF1();
        for (int w = 0; w < wf2; w++) pushStep(ST_F2, S_RD, 1'b0, rop(), rbit(), rbit());
        pushStep(ST_F2, S_RD | S_IRL | S_PCI, 1'b1, rop(), rbit(), rbit());
        dsig = 13'h0;
        if (op == 4'h5) dsig = S_PCL;
        if (op == 4'h6 && az) dsig = S_PCL;
        if (!legal_op(op)) dsig = S_ILL;
        pushStep(ST_DEC, dsig, rbit(), op, az, rbit());
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4}) begin
            pushStep(ST_EADDR, S_MARL | S_MARS, rbit(), op, rbit(), rbit());
            acc = (op == 4'h2) ? S_WR : S_RD;
            for (int w = 0; w < wmem; w++) pushStep(ST_EMEM, acc, 1'b0, op, rbit(), rbit());
            pushStep(ST_EMEM, acc | ((op == 4'h2) ? 13'h0 : S_MDRL), 1'b1, op, rbit(), rbit());
            if (op != 4'h2) begin
                alu = (op == 4'h3) ? 2'b01 : (op == 4'h4) ? 2'b10 : 2'b00;
                pushStep(ST_EALU, S_ACCL | {7'b0, alu, 4'b0}, rbit(), op, rbit(), rbit());
            end
        end
    endtask

    task automatic applyStimulus(input step_t s);
        @(negedge clk);
        mem_ready = s.ready;
        ir_op     = s.op;
        acc_zero  = s.az;
        start     = s.go;
    endtask

    task automatic checkOutput(input string tag, input state_t est, input logic [12:0] esig);
        logic [16:0] obs;
        logic [16:0] exp;
        #1;
        obs = {state_dbg, pc_load, pc_inc, mar_load, mar_sel, ir_load, mdr_load, acc_load,
               alu_op, mem_rd, mem_wr, halted, illegal};
        exp = {est, esig};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic runQueue(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            applyStimulus(s);
            checkOutput($sformatf("%s/%s", tag, s.st.name()), s.st, s.sig);
        end
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput({tag, "_in_reset"}, ST_IDLE, 13'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        checkOutput({tag, "_released"}, ST_IDLE, 13'h0);
    endtask

    // Starts with F1 already observed; counts cycles until the DUT is back in F1.
    task automatic measureLatency(input logic [3:0] op, input int expected);
        int n;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            ir_op     = op;
            acc_zero  = 1'b0;
            start     = 1'b0;
            #1;
            if (state_dbg == ST_F1) n = i;
        end
        checks++;
        assert (n == expected) else begin
            failures++;
            $error("[TB] FAIL latency_op%h observed=%0d expected=%0d", op, n, expected);
        end
    endtask

    initial begin
        $display("[TB] reset and idle");
        doReset("reset");
        for (int i = 0; i < 10; i++) pushIdle(1'b0);
        runQueue("idle");

        $display("[TB] LDA walk and zero-wait latencies");
        pushIdle(1'b1);
        pushInstr(4'h1, rbit(), 0, 0);
        pushF1();
        runQueue("lda");
        measureLatency(4'h0, 3);
        measureLatency(4'h5, 3);
        measureLatency(4'h6, 3);
        measureLatency(4'h7, 3);
        measureLatency(4'h2, 5);
        measureLatency(4'h1, 6);
        measureLatency(4'h3, 6);
        measureLatency(4'h4, 6);
        doReset("reset2");

        $display("[TB] STA wait states, JZ, illegal opcode");
        pushIdle(1'b1);
        pushInstr(4'h2, rbit(), 0, 3);
        pushInstr(4'h6, 1'b1, 0, 0);
        pushInstr(4'h6, 1'b0, 1, 0);
        pushInstr(4'h7, rbit(), 0, 0);
        pushF1();
        runQueue("directed");
        doReset("reset3");

        $display("[TB] random instruction stream ending in HLT");
        pushIdle(1'b1);
        for (int i = 0; i < 120; i++) begin
            logic [3:0] op;
            op = rop();
            if (op == 4'hF) op = 4'h0;
            pushInstr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        pushInstr(4'hF, rbit(), $urandom_range(0, 2), 0);
        for (int i = 0; i < 20; i++) pushStep(ST_HALT, S_HALT, rbit(), rop(), rbit(), (i % 3) == 0);
        runQueue("random");
        doReset("reset_halt");

        $display("[TB] reset during instruction read");
        pushIdle(1'b1);
        pushF1();
        pushStep(ST_F2, S_RD, 1'b0, rop(), rbit(), 1'b0);
        runQueue("pre_rst");
        #2;
        rst = 1'b1;
        checkOutput("rst_mid_f2", ST_IDLE, 13'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("after_mid_rst", ST_IDLE, 13'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
